wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback stage + architectural register file; consumes the MEM/WB pipeline register outputs.
//  Selects the writeback value (ALU result / memory data / immediate) and commits it to the register file.
//  Provides two read ports to decode and counts retired register writes.
//  A MEM/WB bubble (regWrite=0, targetReg=0, all data 0) commits nothing.
// PARAMETERS
//  DATA_W   8   register / datapath width
//  ADDR_W   3   register address width; NREGS = 2**ADDR_W (8)
//  R0_ZERO  1   1: r0 reads 0 and ignores writes; 0: r0 is an ordinary register
//  CNT_W    16  retire counter width
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst_n        in   1       asynchronous reset, active low
//  wb_en        in   1       regWrite from MEM/WB; commit request
//  wb_sel       in   2       writeback source: 00 ALU, 01 mem, 10 immed, 11 reserved
//  wb_addr      in   ADDR_W  targetReg from MEM/WB
//  alu_result   in   DATA_W  ALUresult from MEM/WB
//  mem_data     in   DATA_W  memData from MEM/WB
//  immed        in   DATA_W  immed from MEM/WB
//  rs_a         in   ADDR_W  read port A address
//  rs_b         in   ADDR_W  read port B address
//  rd_data_a    out  DATA_W  read port A data (combinational)
//  rd_data_b    out  DATA_W  read port B data (combinational)
//  wb_data      out  DATA_W  selected writeback value (combinational; forwarding source)
//  wb_commit    out  1       registered; 1 for one cycle after a committed write
//  retire_cnt   out  CNT_W   registered count of committed writes
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers <= 0, retire_cnt <= 0, wb_commit <= 0.
//    Read ports then return 0. Reset mid-write: the write is lost; registers stay 0 until release.
//  - Source mux: wb_sel 00 -> alu_result, 01 -> mem_data, 10 -> immed.
//    wb_sel 11 -> wb_data = 0 and no commit, regardless of wb_en.
//  - Commit condition: wb_en=1 AND wb_sel!=11 AND NOT (R0_ZERO=1 AND wb_addr==0).
//  - On a commit edge: regs[wb_addr] <= wb_data; wb_commit <= 1.
//  - On a non-commit edge: regs unchanged; wb_commit <= 0.
//  - Latency: the write is visible on read ports on the cycle after the commit edge.
//    A same-cycle read is governed by WB_BYPASS_EN.
//  - retire_cnt increments by 1 per commit and saturates at 2**CNT_W-1 (no wrap).
//  - r0 with R0_ZERO=1: rd_data_* = 0 whenever rs_* == 0, bypass included.
//  - rs_a == rs_b is legal; both ports return identical data.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    if the commit condition holds and rs_x == wb_addr in the same cycle, rd_data_x = wb_data
//    (write-through; removes the WB->ID hazard).
//  WB_BYPASS_EN undefined:
//    rd_data_x = regs[rs_x] only; a same-cycle read returns the old value.
//    Hazard resolution is owned by the hazard unit.
// TESTING
//  1 Reset: rst_n=0 mid-run, then release; read all 8 regs
//    -> all 0x00; retire_cnt=0; wb_commit=0.
//  2 Writes: wb_en=1, sel=00 alu=0x3C addr=2; next cycle sel=01 mem=0xA5 addr=5; then sel=10 imm=0x7F addr=7
//    -> r2=0x3C, r5=0xA5, r7=0x7F; retire_cnt=3.
//  3 r0 and bubble: wb_en=1 addr=0 alu=0xFF (R0_ZERO=1)
//    -> rd(0)=0x00, no commit; all-zero bubble -> no reg change, retire_cnt unchanged.
//  4 Reserved select: wb_en=1 sel=11 addr=3
//    -> wb_data=0, r3 unchanged, wb_commit=0.
//  5 Same-cycle read: r4=0x11; write alu=0x22 addr=4 while rs_a=4
//    -> rd_data_a=0x22 with WB_BYPASS_EN, 0x11 without; 0x22 next cycle in both builds.
//  6 Saturation: CNT_W=4; 20 back-to-back commits -> retire_cnt holds at 15.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and architectural register file. It takes the MEM/WB
//   pipeline register outputs, selects the writeback value (ALU result,
//   memory data or immediate) and commits it to the register file. It also
//   provides two combinational read ports to decode and keeps a saturating
//   count of retired register writes.
//
// Optional feature (compile-time macro):
//   WB_BYPASS_EN  when defined, a read whose address matches a write being
//                 committed in the same cycle returns the value being written.
//                 When undefined, a same-cycle read returns the old contents
//                 and the hazard unit is responsible for resolving it.
//
// Parameters:
//   DATA_W   register / datapath width
//   ADDR_W   register address width (NREGS = 2**ADDR_W)
//   R0_ZERO  1: r0 reads 0 and ignores writes, 0: r0 is ordinary
//   CNT_W    retire counter width
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous reset, active low
//   wb_en       in   regWrite from MEM/WB (commit request)
//   wb_sel      in   writeback source: 00 ALU, 01 mem, 10 immed, 11 reserved
//   wb_addr     in   target register from MEM/WB
//   alu_result  in   ALU result from MEM/WB
//   mem_data    in   memory data from MEM/WB
//   immed       in   immediate from MEM/WB
//   rs_a, rs_b  in   read port addresses
//   rd_data_a   out  read port A data (combinational)
//   rd_data_b   out  read port B data (combinational)
//   wb_data     out  selected writeback value (combinational, forwarding source)
//   wb_commit   out  registered, high for one cycle after a committed write
//   retire_cnt  out  registered, saturating count of committed writes
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] immed,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int NREGS = 1 << ADDR_W;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;
    logic              r0_target;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // r0 is hard-wired to zero when R0_ZERO is set; reads of it never see
    // any stored or forwarded value.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (R0_ZERO != 0) && (a == '0);
    endfunction

    // One read port. The stored value is passed in so the function only
    // depends on its arguments.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              wr_now,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] v;
        v = stored;
`ifdef WB_BYPASS_EN
        if (wr_now && (a == wr_addr)) begin
            v = wr_data;
        end
`else
        if (wr_now && (a == wr_addr) && 1'b0) begin
            v = wr_data;
        end
`endif
        if (is_zero_reg(a)) begin
            v = '0;
        end
        return v;
    endfunction

    // ---- writeback source select (combinational) ----
    always_comb begin
        wb_data = '0;
        unique case (wb_sel)
            SEL_ALU: wb_data = alu_result;
            SEL_MEM: wb_data = mem_data;
            SEL_IMM: wb_data = immed;
            default: wb_data = '0;  // reserved encoding: nothing to write
        endcase
    end

    assign r0_target = is_zero_reg(wb_addr);

    // A reserved select or a write aimed at a hard-wired r0 is dropped even
    // when regWrite is asserted.
    assign commit = wb_en && (wb_sel != 2'b11) && !r0_target;

    // ---- register file and commit bookkeeping (rising edge) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_commit  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            wb_commit <= commit;
            if (commit) begin
                retire_cnt <= sat_inc(retire_cnt);
            end
        end
    end

    // ---- read ports (combinational) ----
    always_comb begin
        rd_data_a = read_port(rs_a, regs[rs_a], commit, wb_addr, wb_data);
        rd_data_b = read_port(rs_b, regs[rs_b], commit, wb_addr, wb_data);
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
    localparam int R0_ZERO = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_en = 1'b0;
    logic [1:0] wb_sel = 2'b00;
    logic [2:0] wb_addr = 3'd0;
    logic [7:0] alu_result = 8'h00;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] immed = 8'h00;
    logic [2:0] rs_a = 3'd0;
    logic [2:0] rs_b = 3'd0;

    logic [7:0]  rd_data_a, rd_data_b, wb_data;
    logic        wb_commit;
    logic [15:0] retire_cnt;

    logic [7:0]  s_rd_data_a, s_rd_data_b, s_wb_data;
    logic        s_wb_commit;
    logic [3:0]  s_retire_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] mregs [8];
    int         mcnt;
    int         mcnt_s;
    logic       mcommit_q;

    // values observed before the clock edge inside step()
    logic [7:0] obs_a, obs_b, obs_wbd;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_sel(wb_sel), .wb_addr(wb_addr),
        .alu_result(alu_result), .mem_data(mem_data), .immed(immed),
        .rs_a(rs_a), .rs_b(rs_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_data(wb_data), .wb_commit(wb_commit), .retire_cnt(retire_cnt)
    );

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_sel(wb_sel), .wb_addr(wb_addr),
        .alu_result(alu_result), .mem_data(mem_data), .immed(immed),
        .rs_a(rs_a), .rs_b(rs_b), .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
        .wb_data(s_wb_data), .wb_commit(s_wb_commit), .retire_cnt(s_retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_sel(input logic [1:0] sel, input logic [7:0] alu,
                                         input logic [7:0] mem, input logic [7:0] imm);
        if (sel == 2'd0) return alu;
        if (sel == 2'd1) return mem;
        if (sel == 2'd2) return imm;
        return 8'h00;
    endfunction

    function automatic logic m_commit(input logic en, input logic [1:0] sel, input logic [2:0] addr);
        return en && (sel != 2'd3) && !(R0_ZERO == 1 && addr == 3'd0);
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] ra, input logic cm,
                                          input logic [2:0] wa, input logic [7:0] wd);
        if (R0_ZERO == 1 && ra == 3'd0) return 8'h00;
`ifdef WB_BYPASS_EN
        if (cm && ra == wa) return wd;
`endif
        return mregs[ra];
    endfunction

    // Apply one MEM/WB beat, check combinational outputs before the edge and
    // registered outputs after it. Starts and ends just after a rising edge.
    task automatic step(input logic en, input logic [1:0] sel, input logic [2:0] addr,
                        input logic [7:0] alu, input logic [7:0] mem, input logic [7:0] imm,
                        input logic [2:0] ra, input logic [2:0] rb);
        logic       cm;
        logic [7:0] wd;
        wb_en = en; wb_sel = sel; wb_addr = addr;
        alu_result = alu; mem_data = mem; immed = imm;
        rs_a = ra; rs_b = rb;
        cm = m_commit(en, sel, addr);
        wd = m_sel(sel, alu, mem, imm);
        @(negedge clk);
        obs_a = rd_data_a; obs_b = rd_data_b; obs_wbd = wb_data;
        chk("wb_data", {24'h0, wb_data}, {24'h0, wd});
        chk("rd_a", {24'h0, rd_data_a}, {24'h0, m_read(ra, cm, addr, wd)});
        chk("rd_b", {24'h0, rd_data_b}, {24'h0, m_read(rb, cm, addr, wd)});
        @(posedge clk);
        if (cm) begin
            mregs[addr] = wd;
            if (mcnt < 65535) mcnt++;
            if (mcnt_s < 15) mcnt_s++;
        end
        mcommit_q = cm;
        #1;
        chk("wb_commit", {31'h0, wb_commit}, {31'h0, mcommit_q});
        chk("retire_cnt", {16'h0, retire_cnt}, mcnt);
        chk("retire_cnt_sat", {28'h0, s_retire_cnt}, mcnt_s);
    endtask

    // Asynchronous reset in the middle of a cycle while a write is pending.
    task automatic do_reset();
        @(posedge clk);
        #3;
        wb_en = 1'b1; wb_sel = 2'b00; wb_addr = 3'd6; alu_result = 8'h99;
        rs_a = 3'd1; rs_b = 3'd2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mcnt = 0; mcnt_s = 0; mcommit_q = 1'b0;
        chk("rst_async_cnt", {16'h0, retire_cnt}, 32'd0);
        chk("rst_async_commit", {31'h0, wb_commit}, 32'd0);
        chk("rst_async_rd_a", {24'h0, rd_data_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_cnt", {16'h0, retire_cnt}, 32'd0);
        chk("rst_hold_sat", {28'h0, s_retire_cnt}, 32'd0);
        wb_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mcnt = 0; mcnt_s = 0; mcommit_q = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // some traffic before the mid-run reset
        for (int i = 1; i < 8; i++)
            step(1'b1, 2'd0, 3'(i), 8'(8'h10 + i), 8'h00, 8'h00, 3'(i), 3'(7 - i));

        // test 1: reset mid-run, read back every register
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'(i), 3'(7 - i));
            chk("rst_reg_a", {24'h0, obs_a}, 32'd0);
        end
        chk("rst_cnt_after", {16'h0, retire_cnt}, 32'd0);
        chk("rst_commit_after", {31'h0, wb_commit}, 32'd0);

        // test 2: one write from each source
        step(1'b1, 2'd0, 3'd2, 8'h3C, 8'h00, 8'h00, 3'd1, 3'd3);
        step(1'b1, 2'd1, 3'd5, 8'h00, 8'hA5, 8'h00, 3'd1, 3'd3);
        step(1'b1, 2'd2, 3'd7, 8'h00, 8'h00, 8'h7F, 3'd1, 3'd3);
        step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd2, 3'd5);
        chk("r2", {24'h0, obs_a}, 32'h3C);
        chk("r5", {24'h0, obs_b}, 32'hA5);
        step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd7, 3'd7);
        chk("r7", {24'h0, obs_a}, 32'h7F);
        chk("r7_b", {24'h0, obs_b}, 32'h7F);
        chk("cnt3", {16'h0, retire_cnt}, 32'd3);

        // test 3: write to r0 is dropped, bubble commits nothing
        step(1'b1, 2'd0, 3'd0, 8'hFF, 8'h00, 8'h00, 3'd0, 3'd0);
        chk("r0_rd_same", {24'h0, obs_a}, 32'd0);
        chk("r0_commit", {31'h0, wb_commit}, 32'd0);
        step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd2);
        chk("r0_rd", {24'h0, obs_a}, 32'd0);
        chk("bubble_cnt", {16'h0, retire_cnt}, 32'd3);
        chk("bubble_r2", {24'h0, obs_b}, 32'h3C);

        // test 4: reserved select
        step(1'b1, 2'd3, 3'd3, 8'h55, 8'h66, 8'h77, 3'd3, 3'd3);
        chk("rsv_wbdata", {24'h0, obs_wbd}, 32'd0);
        chk("rsv_commit", {31'h0, wb_commit}, 32'd0);
        step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd3, 3'd3);
        chk("rsv_r3", {24'h0, obs_a}, 32'd0);

        // test 5: same-cycle read of a register being written
        step(1'b1, 2'd0, 3'd4, 8'h11, 8'h00, 8'h00, 3'd1, 3'd1);
        step(1'b1, 2'd0, 3'd4, 8'h22, 8'h00, 8'h00, 3'd4, 3'd2);
`ifdef WB_BYPASS_EN
        chk("same_cycle_rd", {24'h0, obs_a}, 32'h22);
`else
        chk("same_cycle_rd", {24'h0, obs_a}, 32'h11);
`endif
        step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd4, 3'd4);
        chk("next_cycle_rd", {24'h0, obs_a}, 32'h22);

        // test 6: saturation of a 4-bit retire counter
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b1, 2'(i % 3), 3'(1 + (i % 7)), 8'(i), 8'(i + 40), 8'(i + 80), 3'(i % 8), 3'd0);
        chk("sat_hold15", {28'h0, s_retire_cnt}, 32'd15);
        chk("cnt20", {16'h0, retire_cnt}, 32'd20);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic       en;
            logic [1:0] sel;
            logic [2:0] addr, ra, rb;
            en   = ($urandom_range(0, 3) != 0);
            sel  = 2'($urandom_range(0, 3));
            addr = 3'($urandom_range(0, 7));
            ra   = ($urandom_range(0, 2) == 0) ? addr : 3'($urandom_range(0, 7));
            rb   = ($urandom_range(0, 3) == 0) ? addr : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                step(1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, ra, rb);
            else
                step(en, sel, addr, 8'($urandom), 8'($urandom), 8'($urandom), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
